// File: rtl/rf80386_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rf80386_pkg - FTA bus types and arbiter constants
// Revision: 1.0
// ============================================================================
package rf80386_pkg;

   typedef struct packed {
      logic [5:0] core;
      logic [2:0] channel;
      logic [6:0] tranid;
   } fta_tranid_t;

   typedef struct packed {
      fta_tranid_t   tid;
      logic          cyc;
      logic          stb;
      logic          we;
      logic [15:0]   sel;
      logic [31:0]   adr;
      logic [127:0]  dat;
   } fta_cmd_request128_t;

   typedef struct packed {
      fta_tranid_t   tid;
      logic          ack;
      logic          rty;
      logic          err;
      logic [31:0]   adr;
      logic [127:0]  dat;
   } fta_cmd_response128_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RETRY = 2'd3
   } arb_state_t;

   localparam logic [2:0] ARB_CHAN_I = 3'd1;
   localparam logic [2:0] ARB_CHAN_D = 3'd2;

   // Turns a held requester command into the bus-ready form.
   function automatic fta_cmd_request128_t arb_stamp(
      input fta_cmd_request128_t req,
      input logic [5:0]          core,
      input logic [2:0]          chan
   );
      fta_cmd_request128_t r;
      r             = req;
      r.cyc         = 1'b1;
      r.stb         = 1'b1;
      r.tid.core    = core;
      r.tid.channel = chan;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rf80386_arb_slot.sv
`default_nettype none
// ============================================================================
// Module  : rf80386_arb_slot - one-entry request hold with sticky overflow
// Revision: 1.0
// ============================================================================
module rf80386_arb_slot
   import rf80386_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                load,
   input  logic                clear,
   input  fta_cmd_request128_t req_in,
   output fta_cmd_request128_t req_out,
   output logic                full,
   output logic                ovf
);

   logic                r_full;
   logic                r_ovf;
   fta_cmd_request128_t r_req;

   // A slot being freed this cycle can take the incoming pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_full <= 1'b0;
         r_ovf  <= 1'b0;
         r_req  <= '0;
      end else begin
         if (load && (!r_full || clear)) begin
            r_full <= 1'b1;
            r_req  <= req_in;
         end else if (clear) begin
            r_full <= 1'b0;
         end
         if (load && r_full && !clear)
            r_ovf <= 1'b1;
      end
   end

   assign req_out = r_req;
   assign full    = r_full;
   assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: rtl/rf80386_fta_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rf80386_fta_arbiter - I-cache / data-path share of one FTA master
//           port. Optional macro RF80386_ARB_TIMEOUT_EN adds a WAIT timeout.
// Revision: 1.0
// ============================================================================
module rf80386_fta_arbiter
   import rf80386_pkg::*;
#(
   parameter logic [5:0] CORENO     = 6'd1,
   parameter logic [2:0] CHAN_I     = ARB_CHAN_I,
   parameter logic [2:0] CHAN_D     = ARB_CHAN_D,
   parameter logic [3:0] STARVE_MAX = 4'd8,
   parameter logic [4:0] RTY_WAIT   = 5'd8,
   parameter logic [9:0] TIMEOUT    = 10'd1023
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  fta_cmd_request128_t  i_req,
   output fta_cmd_response128_t i_resp,
   input  fta_cmd_request128_t  d_req,
   output fta_cmd_response128_t d_resp,
   output fta_cmd_request128_t  m_req,
   input  fta_cmd_response128_t m_resp,
   output logic                 busy_o,
   output logic                 ovf_o
);

   arb_state_t           r_state;
   arb_state_t           w_state_d;
   logic                 r_owner_d;
   logic [3:0]           r_starve;
   logic [4:0]           r_backoff;
   fta_cmd_request128_t  r_held;
   fta_cmd_request128_t  r_m_req;
   fta_cmd_response128_t r_i_resp;
   fta_cmd_response128_t r_d_resp;

   fta_cmd_request128_t  w_i_slot;
   fta_cmd_request128_t  w_d_slot;
   fta_cmd_request128_t  w_stamped;
   logic                 w_i_full, w_d_full, w_i_ovf, w_d_ovf;
   logic                 w_grant_i, w_grant_d, w_clr_i, w_clr_d;
   logic                 w_ack, w_rty, w_tmo, w_reissue, w_match;

`ifdef RF80386_ARB_TIMEOUT_EN
   localparam logic [9:0] C_TMO_LAST = TIMEOUT - 10'd1;
   logic [9:0]           r_wait_cnt;
`endif

   rf80386_arb_slot u_slot_i (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load    (i_req.cyc & i_req.stb),
      .clear   (w_clr_i),
      .req_in  (i_req),
      .req_out (w_i_slot),
      .full    (w_i_full),
      .ovf     (w_i_ovf)
   );

   rf80386_arb_slot u_slot_d (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load    (d_req.cyc & d_req.stb),
      .clear   (w_clr_d),
      .req_in  (d_req),
      .req_out (w_d_slot),
      .full    (w_d_full),
      .ovf     (w_d_ovf)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         r_state <= IDLE;
      else
         r_state <= w_state_d;
   end

   always_comb begin
      w_state_d = r_state;
      w_grant_i = 1'b0;
      w_grant_d = 1'b0;
      w_ack     = 1'b0;
      w_rty     = 1'b0;
      w_tmo     = 1'b0;
      w_reissue = 1'b0;
      w_match   = (m_resp.tid.channel == (r_owner_d ? CHAN_D : CHAN_I));
      case (r_state)
         IDLE: begin
            if (w_d_full && (!w_i_full || (r_starve < STARVE_MAX))) begin
               w_grant_d = 1'b1;
               w_state_d = ISSUE;
            end else if (w_i_full) begin
               w_grant_i = 1'b1;
               w_state_d = ISSUE;
            end
         end
         ISSUE: w_state_d = WAIT;
         WAIT: begin
            // ack has priority over rty when both are raised.
            if (m_resp.ack && w_match) begin
               w_ack     = 1'b1;
               w_state_d = IDLE;
            end else if (m_resp.rty && w_match) begin
               w_rty     = 1'b1;
               w_state_d = RETRY;
            end
`ifdef RF80386_ARB_TIMEOUT_EN
            else if (r_wait_cnt == C_TMO_LAST) begin
               w_tmo     = 1'b1;
               w_state_d = IDLE;
            end
`endif
         end
         RETRY: begin
            if (r_backoff <= 5'd1) begin
               w_reissue = 1'b1;
               w_state_d = ISSUE;
            end
         end
         default: w_state_d = IDLE;
      endcase
      w_clr_i = (w_ack | w_tmo) & ~r_owner_d;
      w_clr_d = (w_ack | w_tmo) &  r_owner_d;
   end

   assign w_stamped = w_grant_d ? arb_stamp(w_d_slot, CORENO, CHAN_D)
                                : arb_stamp(w_i_slot, CORENO, CHAN_I);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_owner_d <= 1'b0;
         r_starve  <= '0;
         r_backoff <= '0;
         r_held    <= '0;
         r_m_req   <= '0;
         r_i_resp  <= '0;
         r_d_resp  <= '0;
`ifdef RF80386_ARB_TIMEOUT_EN
         r_wait_cnt <= '0;
`endif
      end else begin
         r_m_req  <= '0;
         r_i_resp <= '0;
         r_d_resp <= '0;
         if (w_grant_d || w_grant_i) begin
            r_owner_d <= w_grant_d;
            r_held    <= w_stamped;
            r_m_req   <= w_stamped;
         end
         if (w_reissue)
            r_m_req <= r_held;
         if (w_grant_i)
            r_starve <= '0;
         else if (w_grant_d && w_i_full)
            r_starve <= r_starve + 4'd1;
         // Loaded one short so the reissue lands RTY_WAIT cycles after rty.
         if (w_rty)
            r_backoff <= RTY_WAIT - 5'd1;
         else if (r_state == RETRY)
            r_backoff <= r_backoff - 5'd1;
         if (w_ack) begin
            if (r_owner_d)
               r_d_resp <= m_resp;
            else
               r_i_resp <= m_resp;
         end
`ifdef RF80386_ARB_TIMEOUT_EN
         if (r_state == WAIT)
            r_wait_cnt <= r_wait_cnt + 10'd1;
         else
            r_wait_cnt <= '0;
         if (w_tmo) begin
            if (r_owner_d) begin
               r_d_resp     <= '0;
               r_d_resp.ack <= 1'b1;
               r_d_resp.err <= 1'b1;
               r_d_resp.dat <= '1;
               r_d_resp.tid <= r_held.tid;
            end else begin
               r_i_resp     <= '0;
               r_i_resp.ack <= 1'b1;
               r_i_resp.err <= 1'b1;
               r_i_resp.dat <= '1;
               r_i_resp.tid <= r_held.tid;
            end
         end
`endif
      end
   end

   assign m_req  = r_m_req;
   assign i_resp = r_i_resp;
   assign d_resp = r_d_resp;
   assign busy_o = (r_state != IDLE) | w_i_full | w_d_full;
   assign ovf_o  = w_i_ovf | w_d_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rf80386_fta_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rf80386_fta_arbiter - directed + randomized bench for the arbiter
// Revision: 1.0
// ============================================================================
module tb_rf80386_fta_arbiter;
   import rf80386_pkg::*;

   localparam logic [2:0] CI     = 3'd1;
   localparam logic [2:0] CD     = 3'd2;
   localparam int         STARVE = 8;
   localparam int         RTYW   = 8;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b1;
   fta_cmd_request128_t  i_req = '0;
   fta_cmd_request128_t  d_req = '0;
   fta_cmd_response128_t m_resp = '0;
   fta_cmd_request128_t  m_req;
   fta_cmd_response128_t i_resp, d_resp;
   logic                 busy_o, ovf_o;

   int total = 0;
   int bad   = 0;
   int cycle = 0;
   int junk  = 0;

   fta_cmd_request128_t  mq[$];
   int                   mc[$];
   fta_cmd_response128_t iq[$], dq[$];
   int                   ic[$], dc[$];

   rf80386_fta_arbiter dut (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .i_req  (i_req),
      .i_resp (i_resp),
      .d_req  (d_req),
      .d_resp (d_resp),
      .m_req  (m_req),
      .m_resp (m_resp),
      .busy_o (busy_o),
      .ovf_o  (ovf_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cycle <= cycle + 1;

   always @(negedge clk_i) begin
      if (m_req.cyc) begin mq.push_back(m_req); mc.push_back(cycle); end
      if (i_resp.ack) begin iq.push_back(i_resp); ic.push_back(cycle); end
      if (d_resp.ack) begin dq.push_back(d_resp); dc.push_back(cycle); end
      if ((m_req != '0 && !m_req.cyc) || (i_resp != '0 && !i_resp.ack) ||
          (d_resp != '0 && !d_resp.ack))
         junk <= junk + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cycle);
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk_i); #1; end
   endtask

   task automatic wait_until(input int c);
      while (cycle < c) step(1);
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic fta_cmd_request128_t mk_req();
      fta_cmd_request128_t r;
      r     = '0;
      r.cyc = 1'b1;
      r.stb = 1'b1;
      r.we  = 1'($urandom_range(0, 1));
      r.sel = 16'($urandom);
      r.adr = $urandom;
      r.dat = {$urandom, $urandom, $urandom, $urandom};
      r.tid = 16'($urandom);
      return r;
   endfunction

   // Bus-side view of what the arbiter must present for a held request.
   function automatic fta_cmd_request128_t exp_stamp(input fta_cmd_request128_t r, input logic [2:0] ch);
      fta_cmd_request128_t e;
      e             = r;
      e.cyc         = 1'b1;
      e.stb         = 1'b1;
      e.tid.core    = 6'd1;
      e.tid.channel = ch;
      return e;
   endfunction

   function automatic fta_cmd_response128_t mk_ack(input fta_tranid_t t);
      fta_cmd_response128_t s;
      s     = '0;
      s.tid = t;
      s.ack = 1'b1;
      s.rty = ($urandom_range(0, 3) == 0);
      s.err = 1'($urandom_range(0, 1));
      s.adr = $urandom;
      s.dat = {$urandom, $urandom, $urandom, $urandom};
      return s;
   endfunction

   task automatic pulse(input bit do_i, input bit do_d, input fta_cmd_request128_t ri,
                        input fta_cmd_request128_t rd, output int n);
      if (do_i) i_req = ri;
      if (do_d) d_req = rd;
      n = cycle;
      step(1);
      i_req = '0;
      d_req = '0;
   endtask

   task automatic drive(input fta_cmd_response128_t s, output int a);
      m_resp = s;
      a = cycle;
      step(1);
      m_resp = '0;
   endtask

   task automatic wait_mreq(output fta_cmd_request128_t r, output int c);
      int b = 0;
      while (mq.size() == 0 && b < 64) begin step(1); b++; end
      if (mq.size() == 0) begin
         chk("mreq_wait_expired", 256'(0), 256'(1));
         r = '0;
         c = -1;
      end else begin
         r = mq.pop_front();
         c = mc.pop_front();
      end
   endtask

   task automatic wait_resp(input bit is_d, input int budget, output fta_cmd_response128_t s, output int c);
      int b = 0;
      while ((is_d ? dq.size() : iq.size()) == 0 && b < budget) begin step(1); b++; end
      if ((is_d ? dq.size() : iq.size()) == 0) begin
         chk(is_d ? "dresp_wait_expired" : "iresp_wait_expired", 256'(0), 256'(1));
         s = '0;
         c = -1;
      end else if (is_d) begin
         s = dq.pop_front();
         c = dc.pop_front();
      end else begin
         s = iq.pop_front();
         c = ic.pop_front();
      end
   endtask

   // One granted transaction: optional single retry, then ack after dly cycles.
   task automatic do_txn(input string tag, input bit is_d, input fta_cmd_request128_t req,
                         input bit use_rty, input int dly, output int c_first, output int a_ack);
      fta_cmd_request128_t  got, e;
      fta_cmd_response128_t s, rr;
      int c, a, rc;
      e = exp_stamp(req, is_d ? CD : CI);
      wait_mreq(got, c);
      c_first = c;
      chk({tag, "_mreq"}, 256'(got), 256'(e));
      if (use_rty) begin
         s     = '0;
         s.rty = 1'b1;
         s.tid = e.tid;
         wait_until(c + dly);
         drive(s, a);
         wait_mreq(got, c);
         chk({tag, "_reissue_cycle"}, 256'(c), 256'(a + RTYW));
         chk({tag, "_reissue"}, 256'(got), 256'(e));
      end
      s = mk_ack(e.tid);
      wait_until(c + dly);
      drive(s, a);
      a_ack = a;
      wait_resp(is_d, 64, rr, rc);
      chk({tag, "_resp"}, 256'(rr), 256'(s));
      chk({tag, "_resp_cycle"}, 256'(rc), 256'(a + 1));
   endtask

   initial begin
      fta_cmd_request128_t  ri, rd, got;
      fta_cmd_response128_t s, rr;
      int n, c, a, rc, left, sm;
      bit ip, dp, expd;

      // Reset state
      #1;
      chk("rst_mreq", 256'(m_req), 256'(0));
      chk("rst_resp", 256'({i_resp, d_resp}), 256'(0));
      chk("rst_flags", 256'({busy_o, ovf_o}), 256'(0));
      step(2);
      rst_i = 1'b0;
      step(2);

      // Single D pulse, bus acks 3 cycles after m_req
      rd = mk_req();
      pulse(0, 1, '0, rd, n);
      do_txn("d1", 1, rd, 0, 3, c, a);
      chk("d1_latency", 256'(c), 256'(n + 2));
      step(3);
      chk("d1_i_quiet", 256'(iq.size()), 256'(0));
      chk("d1_idle", 256'({busy_o, ovf_o}), 256'(0));

      // Simultaneous I and D: D first, I right after D's ack
      ri = mk_req();
      rd = mk_req();
      pulse(1, 1, ri, rd, n);
      do_txn("both_d", 1, rd, 0, 2, c, a);
      do_txn("both_i", 0, ri, 0, 2, c, rc);
      chk("both_i_after_ack", 256'(c), 256'(a + 2));

      // Wrong-channel ack ignored, then rty, then ack
      rd = mk_req();
      pulse(0, 1, '0, rd, n);
      wait_mreq(got, c);
      chk("rty_first", 256'(got), 256'(exp_stamp(rd, CD)));
      s = mk_ack(got.tid);
      s.tid.channel = 3'd5;
      wait_until(c + 1);
      drive(s, a);
      s     = '0;
      s.rty = 1'b1;
      s.tid = got.tid;
      drive(s, a);
      wait_mreq(rd, c);
      chk("rty_reissue_cycle", 256'(c), 256'(a + RTYW));
      chk("rty_same_tid", 256'(rd), 256'(got));
      s = mk_ack(got.tid);
      wait_until(c + 3);
      drive(s, a);
      wait_resp(1, 64, rr, rc);
      chk("rty_resp", 256'(rr), 256'(s));
      step(4);
      chk("rty_single_resp", 256'(dq.size() + iq.size()), 256'(0));

      // I held while a D stream refills its slot on every ack
      ip = 1; dp = 1; sm = 0; left = STARVE;
      pulse(1, 1, mk_req(), mk_req(), n);
      for (int g = 0; g < STARVE + 2; g++) begin
         expd = dp && (!ip || sm < STARVE);
         if (!expd) sm = 0;
         else if (ip) sm++;
         wait_mreq(got, c);
         chk("starve_chan", 256'(got.tid.channel), 256'(expd ? CD : CI));
         s = mk_ack(got.tid);
         wait_until(c + 1);
         if (expd) begin
            dp = (left > 0);
            if (left > 0) begin d_req = mk_req(); left--; end
         end else begin
            ip = 0;
         end
         m_resp = s;
         step(1);
         m_resp = '0;
         d_req  = '0;
         wait_resp(got.tid.channel == CD, 64, rr, rc);
      end
      step(4);
      chk("starve_done", 256'({busy_o, 1'(mq.size() == 0)}), 256'(1));

      // Randomized traffic
      for (int k = 0; k < 12; k++) begin
         int m;
         m  = $urandom_range(1, 3);
         ri = mk_req();
         rd = mk_req();
         pulse(m[0], m[1], ri, rd, n);
         if (m[1]) do_txn("rnd_d", 1, rd, ($urandom_range(0, 2) == 0), $urandom_range(1, 4), c, a);
         if (m[0]) do_txn("rnd_i", 0, ri, ($urandom_range(0, 2) == 0), $urandom_range(1, 4), c, a);
         step(3);
         chk("rnd_stray", 256'(iq.size() + dq.size() + mq.size()), 256'(0));
      end
      chk("rnd_no_ovf", 256'(ovf_o), 256'(0));

      // Pulse on an occupied slot is dropped and flagged
      rd = mk_req();
      pulse(0, 1, '0, rd, n);
      pulse(0, 1, '0, mk_req(), n);
      chk("ovf_set", 256'(ovf_o), 256'(1));
      do_txn("ovf_txn", 1, rd, 0, 2, c, a);
      step(6);
      chk("ovf_one_mreq", 256'(mq.size()), 256'(0));

      // Reset in the middle of WAIT
      rd = mk_req();
      pulse(0, 1, '0, rd, n);
      wait_mreq(got, c);
      wait_until(c + 2);
      #2;
      rst_i = 1'b1;
      #1;
      chk("rstw_outputs", 256'({m_req, busy_o, ovf_o}), 256'(0));
      chk("rstw_resp", 256'({i_resp, d_resp}), 256'(0));
      #3;
      rst_i = 1'b0;
      step(1);
      drive(mk_ack(got.tid), a);
      step(4);
      chk("rstw_late_ack", 256'(dq.size() + iq.size() + mq.size()), 256'(0));

`ifdef RF80386_ARB_TIMEOUT_EN
      rd = mk_req();
      pulse(0, 1, '0, rd, n);
      wait_mreq(got, c);
      wait_resp(1, 1200, rr, rc);
      s     = '0;
      s.ack = 1'b1;
      s.err = 1'b1;
      s.dat = '1;
      s.tid = exp_stamp(rd, CD).tid;
      chk("tmo_resp", 256'(rr), 256'(s));
      chk("tmo_cycle", 256'(rc), 256'(c + 1024));
      drive(mk_ack(got.tid), a);
      step(4);
      chk("tmo_late_ack", 256'({1'(dq.size() != 0), busy_o}), 256'(0));
`endif

      chk("junk_free", 256'(junk), 256'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
